div_iter: RTL

- Iterative radix-2 restoring divider; the inverse-direction companion to the inferred multiplier in the same arithmetic test area.
- Computes quotient or remainder of inpA / inpB, signed or unsigned, with RISC-V DIV/DIVU/REM/REMU result semantics.
- Used as the division path beside the multiplier in Fomu DSP/CPU experiments.
- Multi-cycle with start/busy/done handshake; trades latency for iCE40 LUT count.

---
 rtl/div_iter.sv | 78 +++++++
 1 files changed

// File: rtl/div_iter.sv
// div_iter: iterative radix-2 restoring divider with RISC-V DIV/DIVU/REM/REMU semantics.
// Optional DIV_ZERO_FASTPATH_EN skips the CALC phase when the divisor is zero.
module div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [WIDTH-1:0] inpA,
    input  logic [WIDTH-1:0] inpB,
    input  logic             div_signed,
    input  logic             rem_sel,
    output logic [WIDTH-1:0] out,
    output logic             i_done,
    output logic             busy
);
    localparam int CW = $clog2(WIDTH);
    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_t;
    state_t state, state_nx;
    logic [WIDTH-1:0] rem, quot, dvs, a_mag, b_mag;
    logic [WIDTH:0] trial;
    logic [CW-1:0] count;
    logic qneg, rneg, rsel, bz, accept, fast;
    assign a_mag = (div_signed & inpA[WIDTH-1]) ? -inpA : inpA;
    assign b_mag = (div_signed & inpB[WIDTH-1]) ? -inpB : inpB;
    assign trial = {rem, quot[WIDTH-1]} - {1'b0, dvs};
    assign accept = state == IDLE && start;
    assign busy = state != IDLE;
`ifdef DIV_ZERO_FASTPATH_EN
    assign fast = inpB == '0;
`else
    assign fast = 1'b0;
`endif
    always_comb begin
        state_nx = state;
        case (state)
            IDLE: state_nx = start ? (fast ? FIX : CALC) : IDLE;
            CALC: state_nx = count == '0 ? FIX : CALC;
            FIX:  state_nx = DONE;
            DONE: state_nx = IDLE;
        endcase
    end
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state  <= IDLE;
            out    <= '0;
            i_done <= 1'b0;
            rem    <= '0;
            quot   <= '0;
            dvs    <= '0;
            count  <= '0;
            qneg   <= 1'b0;
            rneg   <= 1'b0;
            rsel   <= 1'b0;
            bz     <= 1'b0;
        end else begin
            state  <= state_nx;
            i_done <= state == DONE;
            if (accept) begin
                // zero-divisor fast path preloads the final rem/quot so FIX needs no special case
                rem   <= fast ? a_mag : '0;
                quot  <= fast ? '1 : a_mag;
                dvs   <= b_mag;
                count <= CW'(WIDTH - 1);
                qneg  <= div_signed & (inpA[WIDTH-1] ^ inpB[WIDTH-1]) & (inpB != '0);
                rneg  <= div_signed & inpA[WIDTH-1];
                rsel  <= rem_sel;
                bz    <= inpB == '0;
            end else if (state == CALC) begin
                rem   <= trial[WIDTH] ? {rem[WIDTH-2:0], quot[WIDTH-1]} : trial[WIDTH-1:0];
                quot  <= {quot[WIDTH-2:0], ~trial[WIDTH]};
                count <= count - 1'b1;
            end else if (state == FIX) begin
                out <= rsel ? (rneg ? -rem : rem) : (bz ? '1 : (qneg ? -quot : quot));
            end
        end
    end
endmodule
